write_frame_sequencer: RTL and testbench
========================================

WRITE_FRAME_SEQUENCER -- requirements
Module: write_frame_sequencer

Interface
REQ-001 Parameter BUF_SIZE, default 8, SHALL be the data word width in bits; it equals the serial write buffer size.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL be the number of queued frames; it SHALL be a power of two and at least 2.
REQ-003 Parameter GAP_CYCLES, default 2, SHALL be the minimum number of idle sys_clk cycles between a wr_done acceptance and the next wr_start; 0 is legal.
REQ-004 Derived COUNT_SIZE SHALL equal $clog2(BUF_SIZE+1), and LVL_SIZE SHALL equal $clog2(FIFO_DEPTH+1).
REQ-005 sys_clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 push  input  1  one-cycle request to enqueue a frame.
REQ-008 push_data  input  BUF_SIZE  frame bits; the MSB is sent first.
REQ-009 push_count  input  COUNT_SIZE  number of valid bits in the frame, legal range 1..BUF_SIZE.
REQ-010 flush  input  1  synchronous discard of all queued, not-yet-loaded frames.
REQ-011 wr_done  input  1  done_sig from the downstream serial write buffer.
REQ-012 wr_start  output  1  one-cycle start pulse to the write buffer.
REQ-013 wr_data  output  BUF_SIZE  data_in to the write buffer, registered.
REQ-014 wr_count  output  COUNT_SIZE  write_count to the write buffer, registered.
REQ-015 full / empty  output  1 each  FIFO status flags, registered.
REQ-016 level  output  LVL_SIZE  number of queued frames.
REQ-017 busy  output  1  high whenever the state is not IDLE.
REQ-018 reject  output  1  one-cycle pulse when a push is dropped.

Function
REQ-019 The FIFO SHALL be a circular buffer with read and write pointers that wrap modulo FIFO_DEPTH; level SHALL be tracked by its own counter.
REQ-020 push SHALL be accepted only when full=0 and 1<=push_count<=BUF_SIZE; otherwise the frame SHALL be dropped and reject SHALL pulse in the next cycle.
REQ-021 full SHALL be evaluated on the registered value: a push while full is rejected even if a pop occurs in the same cycle.
REQ-022 A simultaneous accepted push and pop SHALL leave level unchanged.
REQ-023 FSM states SHALL be IDLE, LOAD, START, GUARD, WAIT_DONE and GAP.
REQ-024 IDLE SHALL go to LOAD when empty=0; LOAD SHALL pop the head entry into wr_data/wr_count and go to START.
REQ-025 START SHALL assert wr_start for exactly one cycle and go to GUARD.
REQ-026 GUARD SHALL ignore wr_done for one cycle and then go to WAIT_DONE.
REQ-027 WAIT_DONE SHALL wait for wr_done=1; it SHALL then go to GAP if GAP_CYCLES>0, otherwise to IDLE.
REQ-028 GAP SHALL count GAP_CYCLES cycles and then go to IDLE.
REQ-029 Latency: a push in cycle N into an empty FIFO while in IDLE SHALL produce wr_start high in cycle N+3 (N+1 IDLE sees empty=0, N+2 LOAD, N+3 START).
REQ-030 wr_data and wr_count SHALL hold their values from LOAD until the next LOAD.
REQ-031 flush SHALL set level=0, empty=1 and full=0 and equalise the pointers in the next cycle; a frame already loaded SHALL complete normally.
REQ-032 flush and push in the same cycle: flush SHALL win, the push SHALL be discarded, and reject SHALL NOT pulse.
REQ-033 wr_done outside WAIT_DONE SHALL be ignored.

Reset
REQ-034 rst=0 SHALL immediately force state IDLE, both pointers 0, level 0, empty=1, full=0, wr_start=0, wr_data=0, wr_count=0, busy=0 and reject=0, regardless of the current state.
REQ-035 FIFO storage contents need not be cleared on reset.
REQ-036 Operation SHALL resume on the first rising sys_clk edge after rst returns to 1.

Verification
REQ-037 Reset, then push {0x9C, 8} with wr_done tied to a model buffer -> wr_start exactly 3 cycles after the push, wr_data=0x9C and wr_count=8 held; busy falls GAP_CYCLES+1 cycles after wr_done.
REQ-038 Push 5 frames back-to-back with FIFO_DEPTH=4 and wr_done held 0 -> the first frame is loaded and the next 4 are queued. Expected: full=1 and level=4; no reject pulses so far.
REQ-039 Continuation of REQ-038: push a 6th frame -> reject pulses once; frames then emerge in order with at least GAP_CYCLES cycles between each wr_done and the next wr_start.
REQ-040 Push with push_count=0 and with push_count=9 -> reject pulses for each; level is unchanged.
REQ-041 Queue 3 frames, then assert flush during WAIT_DONE -> the current frame completes, level=0 and no further wr_start occurs.
REQ-042 Assert rst=0 asynchronously in mid-WAIT_DONE -> all outputs take their reset values within the same cycle, and wr_done pulses arriving afterwards are ignored.
REQ-043 Fill the FIFO and drain it across more than 2*FIFO_DEPTH frames -> the pointers wrap, and data order and values are preserved.

Source files
------------

// File: rtl/write_frame_sequencer.sv
// write_frame_sequencer
//   Queues frames in a small circular FIFO and hands them one at a time to a
//   downstream serial write buffer. Each frame is loaded into wr_data/wr_count,
//   announced with a one-cycle wr_start pulse, and then the sequencer waits for
//   wr_done. After wr_done it observes a programmable idle gap before it
//   starts the next frame.
//
// Handshake semantics:
//   push     - one-cycle request. It is accepted when full=0 and push_count is
//              in 1..BUF_SIZE. A dropped push pulses reject in the next cycle.
//              If flush is asserted in the same cycle, the push is discarded
//              silently.
//   wr_start - one-cycle pulse. wr_data and wr_count are already stable when
//              it rises, and they hold until the next frame is loaded.
//   wr_done  - sampled only in WAIT_DONE. At any other time it is ignored.
//
// Ports:
//   sys_clk, rst (async, active-low)
//   push, push_data[BUF_SIZE], push_count[COUNT_SIZE], flush, wr_done
//   wr_start, wr_data[BUF_SIZE], wr_count[COUNT_SIZE]
//   full, empty, level[LVL_SIZE], busy, reject
//   state_dbg[3] - current FSM state, for observation only
module write_frame_sequencer #(
  parameter int BUF_SIZE   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2,
  localparam int COUNT_SIZE = $clog2(BUF_SIZE + 1),
  localparam int LVL_SIZE   = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [BUF_SIZE-1:0]   push_data,
  input  logic [COUNT_SIZE-1:0] push_count,
  input  logic                  flush,
  input  logic                  wr_done,
  output logic                  wr_start,
  output logic [BUF_SIZE-1:0]   wr_data,
  output logic [COUNT_SIZE-1:0] wr_count,
  output logic                  full,
  output logic                  empty,
  output logic [LVL_SIZE-1:0]   level,
  output logic                  busy,
  output logic                  reject,
  output logic [2:0]            state_dbg
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LVL_SIZE-1:0]   LVL_FULL  = LVL_SIZE'(FIFO_DEPTH);
  localparam logic [COUNT_SIZE-1:0] COUNT_MAX = COUNT_SIZE'(BUF_SIZE);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    GUARD     = 3'd3,
    WAIT_DONE = 3'd4,
    GAP       = 3'd5
  } state_t;

  state_t state, state_next;

  logic [BUF_SIZE-1:0]   data_mem  [FIFO_DEPTH];
  logic [COUNT_SIZE-1:0] count_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [GAP_W-1:0]      gap_cnt;
  logic [LVL_SIZE-1:0]   level_next;
  logic                  count_ok, push_ok, pop;

  assign count_ok = (push_count != '0) && (push_count <= COUNT_MAX);
  // The registered full flag is used here. A pop in the same cycle does not
  // free a slot for this push.
  assign push_ok  = push && !flush && !full && count_ok;
  // A flush in the cycle where IDLE decided to load can leave LOAD with an
  // empty FIFO. In that case nothing is popped.
  assign pop      = (state == LOAD) && !empty;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_comb begin
    level_next = level;
    if (push_ok && !pop) begin
      level_next = level + LVL_SIZE'(1);
    end else if (pop && !push_ok) begin
      level_next = level - LVL_SIZE'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!empty) state_next = LOAD;
      LOAD:      state_next = empty ? IDLE : START;
      START:     state_next = GUARD;
      GUARD:     state_next = WAIT_DONE;
      WAIT_DONE: if (wr_done) state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:       if (gap_cnt == GAP_LAST) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Frame storage is not reset. Only the pointers decide which entries are valid.
  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      data_mem[wr_ptr]  <= push_data;
      count_mem[wr_ptr] <= push_count;
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      wr_start <= 1'b0;
      wr_data  <= '0;
      wr_count <= '0;
      reject   <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_next;
      // Registering wr_start from the next state makes it coincide with START.
      wr_start <= (state_next == START);
      reject   <= push && !flush && (full || !count_ok);

      if (pop) begin
        wr_data  <= data_mem[rd_ptr];
        wr_count <= count_mem[rd_ptr];
      end

      if (state == GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end else begin
        gap_cnt <= '0;
      end

      if (flush) begin
        // Queued frames are discarded. A frame already in wr_data is unaffected.
        rd_ptr <= wr_ptr;
        level  <= '0;
        empty  <= 1'b1;
        full   <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
        level <= level_next;
        empty <= (level_next == '0);
        full  <= (level_next == LVL_FULL);
      end
    end
  end

endmodule

// File: tb/tb_write_frame_sequencer.sv
module tb_write_frame_sequencer;
  localparam int BUF_SIZE   = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int GAP_CYCLES = 2;
  localparam int COUNT_SIZE = $clog2(BUF_SIZE + 1);
  localparam int LVL_SIZE   = $clog2(FIFO_DEPTH + 1);
  localparam int FW         = BUF_SIZE + COUNT_SIZE;
  localparam int RW         = 1 + BUF_SIZE + COUNT_SIZE + 1 + 1 + LVL_SIZE + 1 + 1;
  // {wr_start, wr_data, wr_count, full, empty, level, busy, reject} after reset
  localparam logic [RW-1:0] RST_VEC = RW'(1) << (LVL_SIZE + 2);

  logic                  sys_clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  push = 1'b0;
  logic [BUF_SIZE-1:0]   push_data = '0;
  logic [COUNT_SIZE-1:0] push_count = '0;
  logic                  flush = 1'b0;
  logic                  wr_done = 1'b0;
  logic                  wr_start;
  logic [BUF_SIZE-1:0]   wr_data;
  logic [COUNT_SIZE-1:0] wr_count;
  logic                  full, empty, busy, reject;
  logic [LVL_SIZE-1:0]   level;
  logic [2:0]            state_dbg;

  write_frame_sequencer #(
    .BUF_SIZE(BUF_SIZE), .FIFO_DEPTH(FIFO_DEPTH), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .push(push), .push_data(push_data),
    .push_count(push_count), .flush(flush), .wr_done(wr_done),
    .wr_start(wr_start), .wr_data(wr_data), .wr_count(wr_count),
    .full(full), .empty(empty), .level(level), .busy(busy),
    .reject(reject), .state_dbg(state_dbg)
  );

  // clock
  always #5 sys_clk = ~sys_clk;

  int pass_cnt = 0;
  int check_cnt = 0;
  int cyc = 0;

  // reference model: queued-frame count, accepted frames in order, observations
  int              mlevel;
  int              rej_exp, rej_seen;
  logic [FW-1:0]   exp_q[$];
  logic [FW-1:0]   obs_q[$];
  int              obs_cyc[$];
  int              done_cyc[$];
  bit              auto_done, done_pending;
  int              done_at;

  // One clock cycle, observed at the falling edge. The write buffer model
  // answers each wr_start with wr_done after wr_count shift cycles.
  task automatic cycle();
    @(negedge sys_clk);
    cyc++;
    push = 1'b0; flush = 1'b0; wr_done = 1'b0;
    if (reject === 1'b1) rej_seen++;
    if (wr_start === 1'b1) begin
      mlevel--;
      obs_q.push_back({wr_data, wr_count});
      obs_cyc.push_back(cyc);
      done_pending = 1'b1;
      done_at = cyc + 1 + int'(wr_count);
    end
    if (auto_done && done_pending && cyc >= done_at) begin
      wr_done = 1'b1;
      done_pending = 1'b0;
      done_cyc.push_back(cyc);
    end
  endtask

  task automatic try_push(input logic [BUF_SIZE-1:0] d, input logic [COUNT_SIZE-1:0] c);
    push = 1'b1; push_data = d; push_count = c;
    if (mlevel < FIFO_DEPTH && c >= 1 && int'(c) <= BUF_SIZE) begin
      mlevel++;
      exp_q.push_back({d, c});
    end else begin
      rej_exp++;
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    rst = 1'b0; push = 1'b0; flush = 1'b0; wr_done = 1'b0;
    repeat (2) @(negedge sys_clk);
    mlevel = 0; rej_exp = 0; rej_seen = 0;
    exp_q.delete(); obs_q.delete(); obs_cyc.delete(); done_cyc.delete();
    auto_done = 1'b0; done_pending = 1'b0; done_at = 0;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [RW-1:0] obs;
    #2 rst = 1'b0;
    #1;
    obs = {wr_start, wr_data, wr_count, full, empty, level, busy, reject};
    check_cnt++;
    if (obs !== RST_VEC) $display("FAIL reset_async: outputs=%h want %h", obs, RST_VEC);
    else pass_cnt++;
    repeat (3) @(negedge sys_clk);
    obs = {wr_start, wr_data, wr_count, full, empty, level, busy, reject};
    check_cnt++;
    if (obs !== RST_VEC) $display("FAIL reset_held: outputs=%h want %h", obs, RST_VEC);
    else pass_cnt++;
  endtask

  task automatic test_single();
    int n, start_c, fall_c, starts, exp_fall;
    bit held;
    do_reset(); auto_done = 1'b1;
    cycle(); cycle();
    n = cyc;
    try_push(8'h9C, COUNT_SIZE'(8));
    start_c = -1; fall_c = -1; starts = 0; held = 1'b1;
    for (int k = 0; k < 60 && fall_c < 0; k++) begin
      cycle();
      if (wr_start === 1'b1) begin
        starts++;
        if (start_c < 0) start_c = cyc;
      end
      if (start_c >= 0 && (wr_data !== 8'h9C || wr_count !== COUNT_SIZE'(8))) held = 1'b0;
      if (start_c >= 0 && cyc > start_c && busy === 1'b0) fall_c = cyc;
    end
    check_cnt++;
    if (start_c != n + 3) $display("FAIL single_latency: start at %0d want %0d", start_c, n + 3);
    else pass_cnt++;
    check_cnt++;
    if (!held) $display("FAIL single_hold: wr_data=%h wr_count=%0d want 9c/8", wr_data, wr_count);
    else pass_cnt++;
    check_cnt++;
    if (starts != 1) $display("FAIL single_pulse: wr_start high %0d cycles want 1", starts);
    else pass_cnt++;
    exp_fall = (done_cyc.size() > 0) ? done_cyc[0] + GAP_CYCLES + 1 : -2;
    check_cnt++;
    if (fall_c != exp_fall) $display("FAIL single_busy_fall: busy fell at %0d want %0d", fall_c, exp_fall);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int k, min_gap, bad_i;
    do_reset(); cycle();
    for (int i = 0; i < 5; i++) begin
      try_push(BUF_SIZE'($urandom), COUNT_SIZE'($urandom_range(1, BUF_SIZE)));
      cycle();
    end
    repeat (3) cycle();
    check_cnt++;
    if (level !== LVL_SIZE'(FIFO_DEPTH) || full !== 1'b1)
      $display("FAIL b2b_full: level=%0d full=%0b want %0d/1", level, full, FIFO_DEPTH);
    else pass_cnt++;
    check_cnt++;
    if (rej_seen != 0 || obs_q.size() != 1)
      $display("FAIL b2b_no_reject: rejects=%0d starts=%0d want 0/1", rej_seen, obs_q.size());
    else pass_cnt++;
    try_push(BUF_SIZE'($urandom), COUNT_SIZE'($urandom_range(1, BUF_SIZE)));
    cycle(); cycle();
    check_cnt++;
    if (rej_seen != 1) $display("FAIL b2b_reject: rejects=%0d want 1", rej_seen);
    else pass_cnt++;
    auto_done = 1'b1;
    for (k = 0; k < 500; k++) begin
      cycle();
      if (obs_q.size() >= exp_q.size() && busy === 1'b0) break;
    end
    check_cnt++;
    if (k >= 500) $display("FAIL b2b_drain: timeout, %0d of %0d frames started", obs_q.size(), exp_q.size());
    else pass_cnt++;
    bad_i = (obs_q.size() == exp_q.size()) ? -1 : 999;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i] && bad_i < 0) bad_i = i;
    check_cnt++;
    if (bad_i >= 0) $display("FAIL b2b_order: first bad frame %0d, seen %0d frames want %0d", bad_i, obs_q.size(), exp_q.size());
    else pass_cnt++;
    min_gap = 1000;
    for (int i = 1; i < obs_cyc.size(); i++)
      if (i - 1 < done_cyc.size() && obs_cyc[i] - done_cyc[i-1] - 1 < min_gap)
        min_gap = obs_cyc[i] - done_cyc[i-1] - 1;
    check_cnt++;
    if (min_gap < GAP_CYCLES) $display("FAIL b2b_gap: min gap %0d want >= %0d", min_gap, GAP_CYCLES);
    else pass_cnt++;
  endtask

  task automatic test_bad_count();
    do_reset(); cycle();
    try_push(8'h11, COUNT_SIZE'(0)); cycle();
    try_push(8'h22, COUNT_SIZE'(9)); cycle();
    cycle();
    check_cnt++;
    if (rej_seen != 2) $display("FAIL bad_count_reject: rejects=%0d want 2", rej_seen);
    else pass_cnt++;
    check_cnt++;
    if (level !== '0 || empty !== 1'b1 || busy !== 1'b0)
      $display("FAIL bad_count_level: level=%0d empty=%0b busy=%0b want 0/1/0", level, empty, busy);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    int k;
    do_reset(); cycle();
    for (int i = 0; i < 4; i++) begin
      try_push(BUF_SIZE'($urandom), COUNT_SIZE'($urandom_range(1, BUF_SIZE)));
      cycle();
    end
    for (k = 0; k < 20 && obs_q.size() == 0; k++) cycle();
    cycle(); cycle();
    check_cnt++;
    if (level !== LVL_SIZE'(3)) $display("FAIL flush_pre_level: level=%0d want 3", level);
    else pass_cnt++;
    flush = 1'b1; push = 1'b1; push_data = 8'h77; push_count = COUNT_SIZE'(3);
    while (mlevel > 0) begin
      void'(exp_q.pop_back());
      mlevel--;
    end
    cycle();
    check_cnt++;
    if (level !== '0 || empty !== 1'b1 || full !== 1'b0 || reject !== 1'b0)
      $display("FAIL flush_state: level=%0d empty=%0b full=%0b reject=%0b want 0/1/0/0", level, empty, full, reject);
    else pass_cnt++;
    auto_done = 1'b1;
    repeat (40) cycle();
    check_cnt++;
    if (obs_q.size() != 1 || done_cyc.size() != 1 || busy !== 1'b0 || rej_seen != 0)
      $display("FAIL flush_after: starts=%0d dones=%0d busy=%0b rejects=%0d want 1/1/0/0", obs_q.size(), done_cyc.size(), busy, rej_seen);
    else pass_cnt++;
    check_cnt++;
    if (obs_q.size() < 1 || exp_q.size() < 1 || obs_q[0] !== exp_q[0])
      $display("FAIL flush_loaded_frame: seen %0d frames, expected %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [RW-1:0] obs;
    int bad;
    do_reset(); cycle();
    try_push(8'hA5, COUNT_SIZE'(5));
    for (int k = 0; k < 20 && obs_q.size() == 0; k++) cycle();
    cycle(); cycle();
    #2 rst = 1'b0;
    #1;
    obs = {wr_start, wr_data, wr_count, full, empty, level, busy, reject};
    check_cnt++;
    if (obs !== RST_VEC) $display("FAIL async_reset: outputs=%h want %h state=%0d", obs, RST_VEC, state_dbg);
    else pass_cnt++;
    cycle();
    rst = 1'b1;
    mlevel = 0; exp_q.delete(); done_pending = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (i % 3 == 0) wr_done = 1'b1;
      if (busy !== 1'b0 || wr_start !== 1'b0 || empty !== 1'b1) bad++;
    end
    check_cnt++;
    if (bad != 0) $display("FAIL async_done_ignored: %0d active cycles want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int k, target, wfail, bad_i, min_gap;
    do_reset(); auto_done = 1'b1;
    target = 3 * FIFO_DEPTH + 2;
    wfail = 0;
    for (k = 0; k < 4000; k++) begin
      cycle();
      check_cnt++;
      if (level !== LVL_SIZE'(mlevel) || full !== (mlevel == FIFO_DEPTH) || empty !== (mlevel == 0)) begin
        wfail++;
        if (wfail < 5) $display("FAIL wrap_level: cycle %0d level=%0d full=%0b empty=%0b want level %0d", cyc, level, full, empty, mlevel);
      end else pass_cnt++;
      if (exp_q.size() < target) begin
        if ($urandom_range(0, 3) != 0) begin
          if ($urandom_range(0, 9) == 0)
            try_push(BUF_SIZE'($urandom), COUNT_SIZE'(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(BUF_SIZE + 1, (1 << COUNT_SIZE) - 1)));
          else
            try_push(BUF_SIZE'($urandom), COUNT_SIZE'($urandom_range(1, BUF_SIZE)));
        end
      end else if (obs_q.size() >= exp_q.size() && busy === 1'b0) begin
        break;
      end
    end
    check_cnt++;
    if (k >= 4000) $display("FAIL wrap_drain: timeout, %0d of %0d frames started", obs_q.size(), exp_q.size());
    else pass_cnt++;
    bad_i = (obs_q.size() == exp_q.size()) ? -1 : 999;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i] && bad_i < 0) bad_i = i;
    check_cnt++;
    if (bad_i >= 0) $display("FAIL wrap_order: first bad frame %0d, seen %0d frames want %0d", bad_i, obs_q.size(), exp_q.size());
    else pass_cnt++;
    min_gap = 1000;
    for (int i = 1; i < obs_cyc.size(); i++)
      if (i - 1 < done_cyc.size() && obs_cyc[i] - done_cyc[i-1] - 1 < min_gap)
        min_gap = obs_cyc[i] - done_cyc[i-1] - 1;
    check_cnt++;
    if (min_gap < GAP_CYCLES) $display("FAIL wrap_gap: min gap %0d want >= %0d", min_gap, GAP_CYCLES);
    else pass_cnt++;
    check_cnt++;
    if (rej_seen != rej_exp) $display("FAIL wrap_reject: rejects=%0d want %0d", rej_seen, rej_exp);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_count();
    test_flush();
    test_async_reset();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
